shifter8_seq: RTL and testbench

- Multi-cycle 8-bit shifter that sits directly upstream of the 8-bit result register in the Shifter8 datapath and supplies its d input.
- Accepts an operand, an operation and a shift amount on a start pulse.
- Shifts one bit position per clock and presents the final value on q with a one-cycle done pulse.
- Provides a busy/done handshake so the surrounding control issues one request at a time.

---
 rtl/shifter8_seq.sv | 106 ++++++++++
 tb/tb_shifter8_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/shifter8_seq.sv
// Sequential shifter: one bit position per clock. It drives the result register's d input.
// q only changes when the FSM enters DONE (or on reset), so downstream may sample it any cycle.
module shifter8_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_q;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_next;
  logic             w_is_shift;

  // One-position step of the shift register for the latched operation.
  always_comb begin
    w_next = r_sh;
    case (r_op)
      OP_LSL:  w_next = {r_sh[WIDTH-2:0], 1'b0};
      OP_LSR:  w_next = {1'b0, r_sh[WIDTH-1:1]};
      OP_ASR:  w_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
      OP_ROL:  w_next = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};
      OP_ROR:  w_next = {r_sh[0], r_sh[WIDTH-1:1]};
      default: w_next = r_sh;
    endcase
  end

  assign w_is_shift = (op <= OP_ROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_q     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sh   <= d;
            r_op   <= op;
            r_cnt  <= amt;
            r_busy <= 1'b1;
            if (w_is_shift && amt != '0) begin
              r_state <= SHIFT;
            end else begin
              // Zero amount or pass-through completes without shifting.
              r_q     <= d;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        SHIFT: begin
          r_sh  <= w_next;
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_q     <= w_next;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;

endmodule

// File: tb/tb_shifter8_seq.sv
// Directed and randomized checks of shifter8_seq against an arithmetic reference model.
module tb_shifter8_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [2:0] amt;
  logic [7:0] d;
  logic       busy;
  logic       done;
  logic [7:0] q;

  int         n_vec;
  int         n_err;
  logic [7:0] last_q;

  shifter8_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .d     (d),
    .busy  (busy),
    .done  (done),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] dv, input logic [2:0] opv,
                                       input logic [2:0] av);
    logic [7:0]        r;
    logic signed [7:0] s;
    int                n;
    n = int'(av);
    s = dv;
    case (opv)
      3'd0:    r = dv << n;
      3'd1:    r = dv >> n;
      3'd2:    r = s >>> n;
      3'd3:    r = (n == 0) ? dv : ((dv << n) | (dv >> (8 - n)));
      3'd4:    r = (n == 0) ? dv : ((dv >> n) | (dv << (8 - n)));
      default: r = dv;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the very next edge (E0).
  task automatic run(input logic [7:0] dv, input logic [2:0] opv, input logic [2:0] av,
                     input bit poke);
    logic [7:0] e;
    int         lat;
    e   = model(dv, opv, av);
    lat = (opv <= 3'd4 && av != 3'd0) ? int'(av) : 0;
    start = 1'b1; d = dv; op = opv; amt = av;
    for (int i = 0; i <= lat + 1; i++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(i <= lat));
      chk("done", 32'(done), 32'(i == lat));
      chk("q",    32'(q),    32'((i >= lat) ? e : last_q));
      if (poke && i < lat) begin
        start = 1'b1; d = 8'($urandom); op = 3'($urandom); amt = 3'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    last_q = e;
  endtask

  initial begin
    n_vec = 0; n_err = 0; last_q = 8'h00;
    reset = 1'b1; start = 1'b1; d = 8'h55; op = 3'd0; amt = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q",    32'(q),    32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_q",    32'(q),    32'h00);

    run(8'b01111111, 3'd0, 3'd3, 1'b0);
    chk("lsl_val", 32'(q), 32'(8'b11111000));
    run(8'b11101011, 3'd2, 3'd2, 1'b0);
    chk("asr_val", 32'(q), 32'(8'b11111010));
    run(8'b11101011, 3'd1, 3'd7, 1'b0);
    chk("lsr_val", 32'(q), 32'(8'b00000001));
    run(8'b01010101, 3'd4, 3'd1, 1'b0);
    chk("ror_val", 32'(q), 32'(8'b10101010));
    run(8'b11101011, 3'd3, 3'd4, 1'b0);
    chk("rol_val", 32'(q), 32'(8'b10111110));
    run(8'hA5, 3'd0, 3'd0, 1'b0);
    chk("zero_val", 32'(q), 32'hA5);
    run(8'h3C, 3'd7, 3'd5, 1'b0);
    chk("pass_val", 32'(q), 32'h3C);
    run(8'h81, 3'd2, 3'd5, 1'b1);
    chk("poke_val", 32'(q), 32'hFC);

    // Abort: reset lands at E4 while still shifting.
    start = 1'b1; d = 8'h01; op = 3'd0; amt = 3'd6;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy", 32'(busy), 32'h1);
      chk("abort_done", 32'(done), 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_q",    32'(q),    32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    chk("abort_nodone", 32'(done), 32'h0);
    last_q = 8'h00;
    run(8'h96, 3'd3, 3'd2, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom), bit'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
